// File: rtl/launcher_pkg.sv
// rtl/launcher_pkg.sv - shared types and widths for the program launcher
package launcher_pkg;
   localparam int CNT_W = 16;
   localparam int IDX_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      GAP,
      DONE
   } launch_state_t;
endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - 16-bit saturating run-length counter with clear and enable
module cycle_counter
   import launcher_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             Enable,
   output logic [CNT_W-1:0] Value
);

   always_ff @(posedge Clk) begin
      if (Reset || Clear) begin
         Value <= '0;
      end else if (Enable && (Value != {CNT_W{1'b1}})) begin
         Value <= Value + 1'b1;
      end
   end

endmodule

// File: rtl/prog_launcher.sv
// rtl/prog_launcher.sv - sequences Start pulses over 1..4 programs and measures run lengths; PROG_LAUNCHER_TIMEOUT_EN adds hang detection
module prog_launcher
   import launcher_pkg::*;
#(
   parameter int               START_LEN      = 2,
   parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Go,
   input  logic [IDX_W-1:0] NumProgs,
   output logic             Start,
   input  logic             Ack,
   output logic [IDX_W-1:0] ProgIdx,
   output logic [CNT_W-1:0] CycleCount,
   output logic             CountValid,
   output logic             Busy,
   output logic             Done,
   output logic             Timeout
);

   launch_state_t    state, stateNext;
   logic [3:0]       startCnt;
   logic [IDX_W-1:0] numLatched;
   logic [CNT_W-1:0] runCount;
   logic             launch;
   logic             runDone;
   logic             cntClear;
   logic             cntEnable;
`ifdef PROG_LAUNCHER_TIMEOUT_EN
   logic             hitTimeout;
`endif

   cycle_counter uRunCounter (
      .Clk    (Clk),
      .Reset  (Reset),
      .Clear  (cntClear),
      .Enable (cntEnable),
      .Value  (runCount)
   );

   // Ack is only looked at in RUN: a stale Ack from the previous program may still be high in START.
   always_comb begin
      stateNext = state;
      launch    = 1'b0;
      runDone   = 1'b0;
      cntClear  = 1'b0;
      cntEnable = (state == RUN) && !Ack;
`ifdef PROG_LAUNCHER_TIMEOUT_EN
      hitTimeout = 1'b0;
`endif
      case (state)
         IDLE, DONE: begin
            if (Go) begin
               launch    = 1'b1;
               stateNext = START;
            end
         end
         START: begin
            if (startCnt == 4'(START_LEN - 1)) begin
               cntClear  = 1'b1;
               stateNext = RUN;
            end
         end
         RUN: begin
            if (Ack) begin
               runDone   = 1'b1;
               stateNext = GAP;
            end
`ifdef PROG_LAUNCHER_TIMEOUT_EN
            else if (runCount == TIMEOUT_CYCLES - 16'd1) begin
               hitTimeout = 1'b1;
               stateNext  = DONE;
            end
`endif
         end
         GAP: begin
            stateNext = (ProgIdx == numLatched) ? DONE : START;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         startCnt   <= '0;
         numLatched <= '0;
         Start      <= 1'b0;
         ProgIdx    <= '0;
         CycleCount <= '0;
         CountValid <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         state      <= stateNext;
         startCnt   <= (state == START) ? startCnt + 4'd1 : 4'd0;
         Start      <= (stateNext == START);
         Busy       <= (stateNext == START) || (stateNext == RUN) || (stateNext == GAP);
         Done       <= (stateNext == DONE);
         CountValid <= runDone;
         if (launch) begin
            numLatched <= NumProgs;
            ProgIdx    <= '0;
         end
         if (runDone) begin
            CycleCount <= runCount;
         end
         if ((state == GAP) && (ProgIdx != numLatched)) begin
            ProgIdx <= ProgIdx + 2'd1;
         end
      end
   end

`ifdef PROG_LAUNCHER_TIMEOUT_EN
   always_ff @(posedge Clk) begin
      if (Reset || launch) begin
         Timeout <= 1'b0;
      end else if (hitTimeout) begin
         Timeout <= 1'b1;
      end
   end
`else
   logic unusedTimeoutCfg;
   assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
   assign Timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_prog_launcher.sv
// tb/tb_prog_launcher.sv - directed self-checking bench for prog_launcher
module tb_prog_launcher;
   logic        Clk = 1'b0;
   logic        Reset, Go, Ack;
   logic [1:0]  NumProgs, ProgIdx;
   logic [15:0] CycleCount;
   logic        Start, CountValid, Busy, Done, Timeout;
   int          passed = 0;
   int          total  = 0;

   prog_launcher #(.START_LEN(2), .TIMEOUT_CYCLES(16'd20)) dut (
      .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs), .Start(Start),
      .Ack(Ack), .ProgIdx(ProgIdx), .CycleCount(CycleCount), .CountValid(CountValid),
      .Busy(Busy), .Done(Done), .Timeout(Timeout)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else passed++;
   endtask

   // Runs one sequence with a processor model that raises Ack lens[p] RUN cycles after entry
   // and leaves it high (stale) until the next RUN begins.
   task automatic runSeq(input int n, input int l0, input int l1, input int l2, input int l3,
                         input bit ackInit, input bit busyGo);
      int lens[4];
      int strobes = 0, startRun = 0, lowCnt = 0, runCyc = -1, cyc = 0;
      bit prevStart = 1'b0;
      lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
      Ack = ackInit;
      NumProgs = 2'(n);
      Go = 1'b1;
      tick();
      Go = 1'b0;
      check("go_start", Start, 1);
      check("go_idx0", ProgIdx, 0);
      check("go_to_clr", Timeout, 0);
      NumProgs = ~2'(n);
      while (!Done && cyc < 400) begin
         Go = busyGo && (cyc == 5);
         if (CountValid) begin
            if (strobes < 4) check("cyc_count", CycleCount, lens[strobes]);
            check("cv_idx", ProgIdx, strobes);
            strobes++;
         end
         if (Start) begin
            if (lowCnt > 0 && strobes > 0) check("start_gap", lowCnt, lens[strobes-1] + 2);
            lowCnt = 0;
            startRun++;
         end else begin
            if (prevStart) begin
               check("start_len", startRun, 2);
               startRun = 0;
               runCyc = 0;
            end
            if (Busy) lowCnt++;
         end
         if (runCyc >= 0) begin
            if (strobes < 4 && runCyc == lens[strobes]) begin
               Ack = 1'b1;
               runCyc = -1;
            end else begin
               Ack = 1'b0;
               runCyc++;
            end
         end
         prevStart = Start;
         tick();
         cyc++;
      end
      Go = 1'b0;
      check("end_done", Done, 1);
      check("end_busy", Busy, 0);
      check("end_start", Start, 0);
      check("end_idx", ProgIdx, n);
      check("end_strobes", strobes, n + 1);
      check("end_timeout", Timeout, 0);
   endtask

   initial begin
      bit seenCv;
      Reset = 1'b1; Go = 1'b0; Ack = 1'b0; NumProgs = 2'd0;
      tick();
      Go = 1'b1;
      tick();
      Go = 1'b0;
      check("rst_start", Start, 0);
      check("rst_idx", ProgIdx, 0);
      check("rst_cc", CycleCount, 0);
      check("rst_cv", CountValid, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_timeout", Timeout, 0);
      Reset = 1'b0;
      tick();
      check("idle_busy", Busy, 0);

      runSeq(0, 10, 0, 0, 0, 1'b0, 1'b0);
      runSeq(2, 5, 7, 3, 0, 1'b0, 1'b0);
      runSeq(0, 0, 0, 0, 0, 1'b1, 1'b0);
      runSeq(1, 4, 6, 0, 0, 1'b0, 1'b1);
      runSeq(3, 2, 0, 1, 19, 1'b0, 1'b0);

      // reset on RUN cycle 4
      Ack = 1'b0; NumProgs = 2'd1; Go = 1'b1;
      tick();
      Go = 1'b0;
      repeat (6) tick();
      check("mid_busy_pre", Busy, 1);
      check("mid_start_pre", Start, 0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_start", Start, 0);
      check("mid_busy", Busy, 0);
      check("mid_cc", CycleCount, 0);
      check("mid_done", Done, 0);
      runSeq(0, 3, 0, 0, 0, 1'b0, 1'b0);

      // Ack never rises
      Ack = 1'b0; NumProgs = 2'd0; Go = 1'b1;
      tick();
      Go = 1'b0;
      tick();
      tick();
      seenCv = 1'b0;
      for (int i = 0; i < 19; i++) begin
         if (CountValid) seenCv = 1'b1;
         tick();
      end
      check("to_busy_pre", Busy, 1);
      check("to_done_pre", Done, 0);
      tick();
`ifdef PROG_LAUNCHER_TIMEOUT_EN
      check("to_timeout", Timeout, 1);
      check("to_done", Done, 1);
      check("to_busy", Busy, 0);
      check("to_idx", ProgIdx, 0);
      check("to_no_cv", seenCv | CountValid, 0);
      runSeq(0, 1, 0, 0, 0, 1'b0, 1'b0);
`else
      repeat (30) tick();
      check("nto_busy", Busy, 1);
      check("nto_timeout", Timeout, 0);
      check("nto_no_cv", seenCv | CountValid, 0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("nto_rst_busy", Busy, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got expired expected finish");
      $fatal(1);
   end

endmodule

// File: doc/prog_launcher.md
PROG_LAUNCHER -- requirements
Module: prog_launcher

Interface
REQ-001 SHALL have parameter START_LEN, default 2, meaning the number of cycles Start is held high per program launch (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, meaning the RUN-cycle limit before a program is declared hung.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Go, input, 1 bit: request to launch a program sequence.
REQ-006 SHALL have port NumProgs, input, 2 bits: last program index; the sequence runs NumProgs+1 programs (1..4).
REQ-007 SHALL have port Start, output, 1 bit: drives the processor Start input.
REQ-008 SHALL have port Ack, input, 1 bit: the processor done flag, which is level-sensitive.
REQ-009 SHALL have port ProgIdx, output, 2 bits: index of the current or last program.
REQ-010 SHALL have port CycleCount, output, 16 bits: measured run length of the last completed program.
REQ-011 SHALL have port CountValid, output, 1 bit: one-cycle strobe marking a CycleCount update.
REQ-012 SHALL have port Busy, output, 1 bit: high while a sequence is in progress.
REQ-013 SHALL have port Done, output, 1 bit: level; the sequence has finished.
REQ-014 SHALL have port Timeout, output, 1 bit: sticky; a program hung.

Function
REQ-015 SHALL implement the states IDLE, START, RUN, GAP and DONE.
REQ-016 In IDLE or DONE, Go=1 SHALL latch NumProgs, set ProgIdx=0, clear Done and Timeout, and enter START on the next edge.
REQ-017 Go while Busy SHALL be ignored, and NumProgs changes while Busy SHALL have no effect.
REQ-018 In START, Start=1 for exactly START_LEN consecutive cycles, then RUN; Ack SHALL be ignored in START, because a stale Ack from the prior program may still be high.
REQ-019 Start SHALL be 0 in every state other than START.
REQ-020 Entry to RUN SHALL clear the run counter; each RUN cycle with Ack=0 SHALL increment it, saturating at 16'hFFFF.
REQ-021 In RUN with Ack=1, CycleCount SHALL be loaded with the counter value, CountValid=1 in the following cycle only, and the next state SHALL be GAP; Ack high on the first RUN cycle yields CycleCount=0.
REQ-022 GAP SHALL last 1 cycle; if ProgIdx==latched NumProgs then DONE, else ProgIdx+1 and START.
REQ-023 In RUN, if the counter equals TIMEOUT_CYCLES-1 with Ack=0, Timeout SHALL be set to 1, the sequence aborted, the state set to DONE, CountValid stay 0, and ProgIdx hold the hung program index.
REQ-024 If Ack=1 occurs in the same cycle as the timeout condition, Ack SHALL win and the program is treated as normal completion.
REQ-025 Busy SHALL be 1 exactly in START, RUN and GAP; Done SHALL be 1 exactly in DONE.
REQ-026 All outputs SHALL be registered, with no combinational path from Ack or Go to any output.

Reset
REQ-027 Reset=1 SHALL force IDLE on the next edge from any state, including mid-START or mid-RUN.
REQ-028 Reset SHALL force Start=0, ProgIdx=0, CycleCount=0, CountValid=0, Busy=0, Done=0, Timeout=0, and clear the counter.
REQ-029 Reset SHALL take priority over Go.

Configuration
REQ-030 Macro PROG_LAUNCHER_TIMEOUT_EN defined SHALL compile in the timeout behaviour of REQ-023 and REQ-024.
REQ-031 Macro PROG_LAUNCHER_TIMEOUT_EN undefined SHALL tie Timeout to 0, remove the compare logic, and make RUN wait for Ack indefinitely, with the counter still saturating.

Structure
REQ-032 Package launcher_pkg SHALL hold the state enum typedef launch_state_t and the constants CNT_W=16 and IDX_W=2.
REQ-033 Sub-module cycle_counter SHALL implement a 16-bit saturating counter with clear and enable inputs and a value output, instantiated once.

Verification
REQ-034 Bench SHALL cover: START_LEN=2, NumProgs=0, Go pulse, Ack rising 10 RUN cycles after entry -> Start high 2 cycles, CycleCount=10, one CountValid strobe, Done=1, ProgIdx=0.
REQ-035 Bench SHALL cover: NumProgs=2, run lengths 5, 7 and 3 -> three CountValid strobes with CycleCount 5, 7, 3 and ProgIdx 0, 1, 2; Start pulses separated by RUN plus 1 GAP cycle.
REQ-036 Bench SHALL cover: Ack held high throughout START -> no completion detected in START; CycleCount=0 on the first RUN cycle.
REQ-037 Bench SHALL cover: macro defined, TIMEOUT_CYCLES=20, Ack never rises -> Timeout=1 and Done=1 exactly 20 RUN cycles after entry, with no CountValid.
REQ-038 Bench SHALL cover: Reset asserted on RUN cycle 4 -> next edge shows Start=0, Busy=0, CycleCount=0, and a following Go restarts at ProgIdx=0.
REQ-039 Bench SHALL cover: Go asserted while Busy -> no effect; the sequence completes unchanged.
